// File: rtl/core_mdu_seq.sv
// rtl/core_mdu_seq.sv - iterative RV64M multiply/divide sequencer for the EX stage
// Shift-add multiplier and restoring divider behind one IDLE/CALC/DONE FSM; *W forms run WLEN iterations.
module core_mdu_seq #(
   parameter int XLEN = 64,
   parameter int WLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [2:0]      funct3_i,
   input  logic            w_op_i,
   input  logic [XLEN-1:0] oprd1_i,
   input  logic [XLEN-1:0] oprd2_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CW = $clog2(XLEN + 1);
   localparam int RW = XLEN + 1;
   localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [2:0]          r_f3;
   logic                r_w;
   logic                r_neg;
   logic                r_rneg;
   logic [XLEN-1:0]     r_opa;
   logic [XLEN-1:0]     r_opb;
   logic [2*XLEN-1:0]   r_prod;
   logic [XLEN-1:0]     r_quot;
   logic [XLEN:0]       r_rem;
   logic [XLEN-1:0]     r_result;

   logic                w_s1;
   logic                w_s2;
   logic [XLEN-1:0]     w_a;
   logic [XLEN-1:0]     w_b;
   logic                w_a_neg;
   logic                w_b_neg;
   logic [XLEN-1:0]     w_a_mag;
   logic [XLEN-1:0]     w_b_mag;
   logic                w_div_zero;
   logic                w_ovf;
   logic                w_special;
   logic [XLEN-1:0]     w_spec_raw;
   logic [XLEN-1:0]     w_spec_val;

   // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed; DIV/REM both, DIVU/REMU neither.
   assign w_s1 = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
   assign w_s2 = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];

   assign w_a = w_op_i ? {{(XLEN-WLEN){w_s1 & oprd1_i[WLEN-1]}}, oprd1_i[WLEN-1:0]} : oprd1_i;
   assign w_b = w_op_i ? {{(XLEN-WLEN){w_s2 & oprd2_i[WLEN-1]}}, oprd2_i[WLEN-1:0]} : oprd2_i;

   assign w_a_neg = w_s1 & w_a[XLEN-1];
   assign w_b_neg = w_s2 & w_b[XLEN-1];
   assign w_a_mag = w_a_neg ? -w_a : w_a;
   assign w_b_mag = w_b_neg ? -w_b : w_b;

   assign w_div_zero = (w_b == '0);
   assign w_ovf      = ~funct3_i[0] & (w_a == (w_op_i ? MIN_W : MIN_X)) & (&w_b);
   assign w_special  = funct3_i[2] & (w_div_zero | w_ovf);
   assign w_spec_raw = funct3_i[1] ? (w_div_zero ? w_a : '0) : (w_div_zero ? '1 : w_a);
   assign w_spec_val = w_op_i ? {{(XLEN-WLEN){w_spec_raw[WLEN-1]}}, w_spec_raw[WLEN-1:0]} : w_spec_raw;

   logic [XLEN:0]       w_sum;
   logic [2*XLEN-1:0]   w_prod_nx;
   logic [XLEN+1:0]     w_shift;
   logic                w_ge;
   logic [XLEN:0]       w_rem_nx;
   logic [XLEN-1:0]     w_quot_nx;

   assign w_sum     = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_opa : {XLEN{1'b0}})};
   assign w_prod_nx = {w_sum, r_prod[XLEN-1:1]};
   assign w_shift   = {r_rem, r_quot[XLEN-1]};
   assign w_ge      = (w_shift >= {2'b00, r_opb});
   assign w_rem_nx  = w_ge ? RW'(w_shift - {2'b00, r_opb}) : RW'(w_shift);
   assign w_quot_nx = {r_quot[XLEN-2:0], w_ge};

   logic [2*XLEN-1:0]   w_pfull;
   logic [2*XLEN-1:0]   w_pfix;
   logic [XLEN-1:0]     w_qfix;
   logic [XLEN-1:0]     w_rfix;
   logic [XLEN-1:0]     w_raw;
   logic [XLEN-1:0]     w_final;

   // After WLEN iterations the *W product sits XLEN-WLEN bits above the LSB of the product register.
   assign w_pfull = r_w ? {{(XLEN-WLEN){1'b0}}, w_prod_nx[2*XLEN-1:XLEN-WLEN]} : w_prod_nx;
   assign w_pfix  = r_neg ? -w_pfull : w_pfull;
   assign w_qfix  = r_neg ? -w_quot_nx : w_quot_nx;
   assign w_rfix  = r_rneg ? -XLEN'(w_rem_nx) : XLEN'(w_rem_nx);

   always_comb begin
      w_raw = w_rfix;
      case (r_f3)
         3'b000:                 w_raw = w_pfix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_raw = w_pfix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_raw = w_qfix;
         default:                w_raw = w_rfix;
      endcase
   end

   assign w_final = r_w ? {{(XLEN-WLEN){w_raw[WLEN-1]}}, w_raw[WLEN-1:0]} : w_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_f3     <= '0;
         r_w      <= 1'b0;
         r_neg    <= 1'b0;
         r_rneg   <= 1'b0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_prod   <= '0;
         r_quot   <= '0;
         r_rem    <= '0;
         r_result <= '0;
      end else if (flush_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (valid_i) begin
                  r_f3   <= funct3_i;
                  r_w    <= w_op_i;
                  r_neg  <= w_a_neg ^ w_b_neg;
                  r_rneg <= w_a_neg;
                  r_opa  <= w_a_mag;
                  r_opb  <= w_b_mag;
                  r_prod <= {{XLEN{1'b0}}, w_b_mag};
                  // Left-align a *W dividend so the divider always consumes from the top bit.
                  r_quot <= w_op_i ? (w_a_mag << (XLEN - WLEN)) : w_a_mag;
                  r_rem  <= '0;
                  r_cnt  <= w_op_i ? CW'(WLEN) : CW'(XLEN);
                  if (w_special) begin
                     r_result <= w_spec_val;
                     r_state  <= S_DONE;
                  end else begin
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_f3[2]) begin
                  r_rem  <= w_rem_nx;
                  r_quot <= w_quot_nx;
               end else begin
                  r_prod <= w_prod_nx;
               end
               if (r_cnt == CW'(1)) begin
                  r_result <= w_final;
                  r_state  <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall_o  = ((r_state == S_IDLE) & valid_i & ~flush_i) | (r_state == S_CALC);
   assign done_o   = (r_state == S_DONE);
   assign result_o = r_result;

endmodule

// File: tb/tb_core_mdu_seq.sv
// tb/tb_core_mdu_seq.sv - randomized self-checking bench for core_mdu_seq
// Results come from plain SV arithmetic on the RISC-V M rules; latency from the op class.
module tb_core_mdu_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [2:0]  funct3_i;
   logic        w_op_i;
   logic [63:0] oprd1_i;
   logic [63:0] oprd2_i;
   logic        flush_i;
   logic        stall_o;
   logic        done_o;
   logic [63:0] result_o;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] last_res;

   core_mdu_seq dut (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (valid_i),
      .funct3_i (funct3_i),
      .w_op_i   (w_op_i),
      .oprd1_i  (oprd1_i),
      .oprd2_i  (oprd2_i),
      .flush_i  (flush_i),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
      logic [31:0]         a32, b32, r32;
      logic signed [31:0]  sa32, sb32;
      logic signed [63:0]  sa, sb;
      logic signed [127:0] ps;
      logic [127:0]        pu;
      logic [63:0]         r;
      a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      sa = a; sb = b;
      r32 = '0; r = '0; ps = '0; pu = '0;
      if (w) begin
         case (f3)
            3'd0: r32 = a32 * b32;
            3'd4: if (b32 == 0) r32 = '1;
                  else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
                  else r32 = sa32 / sb32;
            3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
            3'd6: if (b32 == 0) r32 = a32;
                  else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
                  else r32 = sa32 % sb32;
            default: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
         endcase
         r = {{32{r32[31]}}, r32};
      end else begin
         case (f3)
            3'd0: r = a * b;
            3'd1: begin ps = sa * sb; r = ps[127:64]; end
            3'd2: begin ps = sa * $signed({1'b0, b}); r = ps[127:64]; end
            3'd3: begin pu = a * b; r = pu[127:64]; end
            3'd4: if (b == 0) r = '1;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                  else r = sa / sb;
            3'd5: if (b == 0) r = '1; else r = a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                  else r = sa % sb;
            default: if (b == 0) r = a; else r = a % b;
         endcase
      end
      return r;
   endfunction

   function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic dz, ov;
      dz = w ? (b[31:0] == 0) : (b == 0);
      ov = ~f3[0] & (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
      if (f3[2] && (dz || ov)) return 1;
      return w ? 33 : 65;
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
      logic [63:0] exp;
      int          elat, lat, nst;
      exp  = ref_model(f3, w, a, b);
      elat = exp_lat(f3, w, a, b);
      funct3_i = f3; w_op_i = w; oprd1_i = a; oprd2_i = b; valid_i = 1'b1;
      #1;
      nst = stall_o ? 1 : 0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!done_o) begin
            if (stall_o) nst++;
            if (lat == 1) check({tag, ".hold"}, result_o, last_res);
         end
         valid_i = 1'b0;
         oprd1_i = {$urandom, $urandom};
         oprd2_i = {$urandom, $urandom};
      end while (!done_o && lat < 200);
      check({tag, ".lat"}, 64'(lat), 64'(elat));
      check({tag, ".res"}, result_o, exp);
      check({tag, ".stall"}, 64'(nst), 64'(elat));
      @(posedge clk); #1;
      check({tag, ".done_low"}, 64'(done_o), 64'd0);
      check({tag, ".kept"}, result_o, exp);
      last_res = exp;
   endtask

   initial begin
      logic [63:0] a, b, a2, b2, exp1, exp2;
      logic [2:0]  f3;
      logic        w;
      int          lat, nd, k;

      rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; funct3_i = '0; w_op_i = 1'b0;
      oprd1_i = '0; oprd2_i = '0; last_res = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.stall", 64'(stall_o), 64'd0);
      check("rst.done", 64'(done_o), 64'd0);
      check("rst.res", result_o, 64'd0);
      rst = 1'b0;

      run_op("mul_7_m3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("mulhu_ones", 3'd3, 1'b0, '1, '1);
      run_op("mulh_ones", 3'd1, 1'b0, '1, '1);
      run_op("mulhsu", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("div_by0", 3'd4, 1'b0, 64'd100, 64'd0);
      run_op("rem_by0", 3'd6, 1'b0, 64'd100, 64'd0);
      run_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1);
      run_op("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1);
      run_op("divw", 3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      run_op("remw", 3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      run_op("divuw", 3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1);
      run_op("mulw", 3'd0, 1'b1, 64'h1234_5678_8000_0001, 64'hDEAD_BEEF_0000_0003);

      // flush during CALC
      funct3_i = 3'd4; w_op_i = 1'b0; oprd1_i = 64'd100; oprd2_i = 64'd7; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      check("fl.calc_stall", 64'(stall_o), 64'd1);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("fl.stall", 64'(stall_o), 64'd0);
      check("fl.done", 64'(done_o), 64'd0);
      check("fl.res", result_o, last_res);
      nd = 0;
      repeat (80) begin @(posedge clk); #1; if (done_o) nd++; end
      check("fl.no_done", 64'(nd), 64'd0);
      run_op("divu_after_flush", 3'd5, 1'b0, 64'd100, 64'd7);

      // flush in IDLE blocks acceptance
      funct3_i = 3'd4; w_op_i = 1'b0; oprd1_i = 64'd1; oprd2_i = 64'd0; valid_i = 1'b1; flush_i = 1'b1;
      #1;
      check("ifl.stall", 64'(stall_o), 64'd0);
      @(posedge clk); #1;
      valid_i = 1'b0; flush_i = 1'b0;
      check("ifl.done", 64'(done_o), 64'd0);
      check("ifl.stall2", 64'(stall_o), 64'd0);
      check("ifl.res", result_o, last_res);

      // reset mid-op
      funct3_i = 3'd0; oprd1_i = {$urandom, $urandom}; oprd2_i = {$urandom, $urandom}; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rmo.res", result_o, 64'd0);
      check("rmo.done", 64'(done_o), 64'd0);
      check("rmo.stall", 64'(stall_o), 64'd0);
      last_res = '0;
      nd = 0;
      repeat (70) begin @(posedge clk); #1; if (done_o) nd++; end
      check("rmo.no_done", 64'(nd), 64'd0);

      // back-to-back with valid_i held
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      exp1 = ref_model(3'd0, 1'b0, a, b);
      funct3_i = 3'd0; w_op_i = 1'b0; oprd1_i = a; oprd2_i = b; valid_i = 1'b1;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!done_o && lat < 200);
      check("b2b.lat1", 64'(lat), 64'd65);
      check("b2b.res1", result_o, exp1);
      a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
      exp2 = ref_model(3'd7, 1'b0, a2, b2);
      funct3_i = 3'd7; oprd1_i = a2; oprd2_i = b2;
      #1;
      check("b2b.done_stall", 64'(stall_o), 64'd0);
      @(posedge clk); #1;
      check("b2b.gap_done", 64'(done_o), 64'd0);
      check("b2b.gap_stall", 64'(stall_o), 64'd1);
      check("b2b.gap_res", result_o, exp1);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!done_o && lat < 200);
      valid_i = 1'b0;
      check("b2b.lat2", 64'(lat), 64'(exp_lat(3'd7, 1'b0, a2, b2)));
      check("b2b.res2", result_o, exp2);
      nd = 0;
      repeat (3) begin @(posedge clk); #1; if (done_o) nd++; end
      check("b2b.no_extra", 64'(nd), 64'd0);
      last_res = exp2;

      for (int i = 0; i < 150; i++) begin
         f3 = 3'($urandom_range(0, 7));
         w  = (f3 == 3'd0 || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         k  = int'($urandom_range(0, 7));
         case (k)
            0: b = w ? {b[63:32], 32'h0} : 64'd0;
            1: begin
               a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
               b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
            end
            2: begin
               a = {{56{a[7]}}, a[7:0]};
               b = {{60{b[3]}}, b[3:0]};
            end
            3: b = b[0] ? '1 : 64'd1;
            default: ;
         endcase
         run_op($sformatf("rnd%0d_f%0d_w%0d", i, f3, w), f3, w, a, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
